// File: rtl/machine_timer.sv
// -----------------------------------------------------------------------------
// machine_timer
//
// Memory-mapped machine timer feeding the CSR file's MIP.MTIP bit. Holds a
// free-running 64-bit mtime counter (advanced by a prescaler tick) and a 64-bit
// mtimecmp compare register, both reachable as 32-bit halves over a simple
// select/read/write bus handshake.
//
// Ports:
//   clk                      core clock
//   rst_n                    synchronous active-low reset
//   timer_select             bus access targets this block this cycle
//   bus_address[3:0]         byte offset; [3:2] selects the register, [1:0] ignored
//   bus_write_enable         write strobe (qualified by timer_select)
//   bus_read_enable          read strobe (qualified by timer_select)
//   bus_write_data[31:0]     write data
//   bus_read_data[31:0]      registered read data, holds between reads
//   bus_read_valid           one-cycle pulse, bus_read_data valid
//   timer_interrupt_request  level interrupt, registered (mtime >= mtimecmp)
//   mtime_out[63:0]          current mtime register value
//
// Register map (bus_address[3:2]):
//   0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI (all RW)
// -----------------------------------------------------------------------------
module machine_timer #(
    parameter int unsigned PRESCALE_DIV = 1,
    parameter int unsigned MTIME_WIDTH  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        timer_select,
    input  logic [3:0]  bus_address,
    input  logic        bus_write_enable,
    input  logic        bus_read_enable,
    input  logic [31:0] bus_write_data,
    output logic [31:0] bus_read_data,
    output logic        bus_read_valid,
    output logic        timer_interrupt_request,
    output logic [63:0] mtime_out
);

    localparam logic [15:0] PRESCALE_LAST  = 16'(PRESCALE_DIV - 1);
    localparam logic [1:0]  OFF_MTIME_LO   = 2'd0;
    localparam logic [1:0]  OFF_MTIME_HI   = 2'd1;
    localparam logic [1:0]  OFF_MTCMP_LO   = 2'd2;
    localparam logic [1:0]  OFF_MTCMP_HI   = 2'd3;

    logic [MTIME_WIDTH-1:0] mtime_q,    mtime_d;
    logic [MTIME_WIDTH-1:0] mtimecmp_q, mtimecmp_d;
    logic [15:0]            prescale_q, prescale_d;
    logic [31:0]            rd_data_q,  rd_data_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   irq_q,      irq_d;

    logic                   wr_s;
    logic                   rd_s;
    logic                   tick_s;
    logic [1:0]             offset_s;
    logic [31:0]            rd_mux_s;

    // Byte-lane bits are not decoded; registers are word-addressed only.
    logic                   unused_addr_s;
    assign unused_addr_s = ^bus_address[1:0];

    assign wr_s     = timer_select & bus_write_enable;
    assign rd_s     = timer_select & bus_read_enable;
    assign offset_s = bus_address[3:2];
    assign tick_s   = (prescale_q == PRESCALE_LAST);

    // Prescaler: counts 0..PRESCALE_DIV-1, ticking on the last count. Bus
    // traffic never touches it, so timebase phase is independent of software.
    always_comb begin
        if (tick_s) begin
            prescale_d = 16'd0;
        end else begin
            prescale_d = prescale_q + 16'd1;
        end
    end

    // mtime / mtimecmp next state. A write to either mtime half takes priority
    // over the tick: the other half keeps its pre-edge value and no carry is
    // applied that cycle.
    always_comb begin
        if (tick_s) begin
            mtime_d = mtime_q + 64'd1;
        end else begin
            mtime_d = mtime_q;
        end
        mtimecmp_d = mtimecmp_q;
        if (wr_s) begin
            case (offset_s)
                OFF_MTIME_LO: mtime_d    = {mtime_q[63:32], bus_write_data};
                OFF_MTIME_HI: mtime_d    = {bus_write_data, mtime_q[31:0]};
                OFF_MTCMP_LO: mtimecmp_d = {mtimecmp_q[63:32], bus_write_data};
                OFF_MTCMP_HI: mtimecmp_d = {bus_write_data, mtimecmp_q[31:0]};
                default:      mtimecmp_d = mtimecmp_q;
            endcase
        end else begin
            mtimecmp_d = mtimecmp_q;
        end
    end

    // Read mux over pre-edge register contents, so a same-cycle read and write
    // of one offset returns the old value.
    always_comb begin
        case (offset_s)
            OFF_MTIME_LO: rd_mux_s = mtime_q[31:0];
            OFF_MTIME_HI: rd_mux_s = mtime_q[63:32];
            OFF_MTCMP_LO: rd_mux_s = mtimecmp_q[31:0];
            OFF_MTCMP_HI: rd_mux_s = mtimecmp_q[63:32];
            default:      rd_mux_s = 32'd0;
        endcase
    end

    // Read response: data holds between reads, valid pulses only on a read.
    always_comb begin
        rd_valid_d = rd_s;
        if (rd_s) begin
            rd_data_d = rd_mux_s;
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Interrupt compare uses registered values, giving a one-cycle lag.
    always_comb begin
        irq_d = (mtime_q >= mtimecmp_q);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            prescale_q <= 16'd0;
            rd_data_q  <= 32'd0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            prescale_q <= prescale_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            irq_q      <= irq_d;
        end
    end

    assign bus_read_data           = rd_data_q;
    assign bus_read_valid          = rd_valid_q;
    assign timer_interrupt_request = irq_q;
    assign mtime_out               = mtime_q;

endmodule

// File: tb/tb_machine_timer.sv
// -----------------------------------------------------------------------------
// tb_machine_timer
//
// Self-checking bench for machine_timer. Two instances: u_dut1 (PRESCALE_DIV=1)
// exercised by a table of one-cycle bus records plus hand-written sequences,
// and u_dut4 (PRESCALE_DIV=4) for prescaler timing. Read expectations for
// u_dut1 go into a scoreboard queue when the read is issued and are popped
// when bus_read_valid is seen.
// -----------------------------------------------------------------------------
module tb_machine_timer;

    logic        clk;
    logic        rst_n;
    logic        rst_n4;
    logic        sel1;
    logic        sel4;
    logic [3:0]  addr;
    logic        we;
    logic        re;
    logic [31:0] wdata;

    logic [31:0] rdata1, rdata4;
    logic        valid1, valid4;
    logic        irq1, irq4;
    logic [63:0] mtime1, mtime4;

    int          errors;
    int          checks;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;
    logic [31:0] sb_exp;

    typedef struct {
        logic        sel;
        logic        we;
        logic        re;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic [63:0] mtime;
        logic        irq;
    } vec_t;

    vec_t vecs[32];

    machine_timer #(.PRESCALE_DIV(1), .MTIME_WIDTH(64)) u_dut1 (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .timer_select            (sel1),
        .bus_address             (addr),
        .bus_write_enable        (we),
        .bus_read_enable         (re),
        .bus_write_data          (wdata),
        .bus_read_data           (rdata1),
        .bus_read_valid          (valid1),
        .timer_interrupt_request (irq1),
        .mtime_out               (mtime1)
    );

    machine_timer #(.PRESCALE_DIV(4), .MTIME_WIDTH(64)) u_dut4 (
        .clk                     (clk),
        .rst_n                   (rst_n4),
        .timer_select            (sel4),
        .bus_address             (addr),
        .bus_write_enable        (we),
        .bus_read_enable         (re),
        .bus_write_data          (wdata),
        .bus_read_data           (rdata4),
        .bus_read_valid          (valid4),
        .timer_interrupt_request (irq4),
        .mtime_out               (mtime4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every read valid on u_dut1 must match the oldest queued value.
    always @(negedge clk) begin
        if (valid1 === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_sb: unexpected read valid, data %h", rdata1);
            end else begin
                sb_exp = exp_q.pop_front();
                chk("rd_sb", 64'(rdata1), 64'(sb_exp));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic s, input logic w, input logic r,
                                input logic [3:0] a, input logic [31:0] d,
                                input logic [31:0] rd, input logic [63:0] mt,
                                input logic irq);
        vec_t v;
        v.sel = s; v.we = w; v.re = r; v.addr = a; v.wdata = d;
        v.rd = rd; v.mtime = mt; v.irq = irq;
        return v;
    endfunction

    // One bus cycle on u_dut1, then compare the post-edge outputs.
    task automatic apply(input vec_t v);
        sel1  = v.sel;
        we    = v.we;
        re    = v.re;
        addr  = v.addr;
        wdata = v.wdata;
        if (v.sel && v.re) begin
            exp_q.push_back(v.rd);
            last_rd = v.rd;
        end
        step();
        sel1 = 1'b0;
        we   = 1'b0;
        re   = 1'b0;
        chk("mtime", mtime1, v.mtime);
        chk("irq", 64'(irq1), 64'(v.irq));
        chk("rvalid", 64'(valid1), 64'(v.sel && v.re));
        if (!(v.sel && v.re)) begin
            chk("rd_hold", 64'(rdata1), 64'(last_rd));
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        last_rd = 32'd0;
        rst_n   = 1'b0;
        rst_n4  = 1'b0;
        sel1    = 1'b0;
        sel4    = 1'b0;
        we      = 1'b0;
        re      = 1'b0;
        addr    = 4'd0;
        wdata   = 32'd0;

        //        sel  we   re   addr   wdata             rd                mtime                    irq
        vecs[0]  = mk(1'b1, 1'b1, 1'b0, 4'd0,  32'hFFFF_FFFE, 32'd0,         64'h0000_0000_FFFF_FFFE, 1'b0);
        vecs[1]  = mk(1'b1, 1'b1, 1'b0, 4'd4,  32'd0,         32'd0,         64'h0000_0000_FFFF_FFFE, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b0, 4'd0,  32'd0,         32'd0,         64'h0000_0000_FFFF_FFFF, 1'b0);
        vecs[3]  = mk(1'b0, 1'b0, 1'b0, 4'd0,  32'd0,         32'd0,         64'h0000_0001_0000_0000, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 1'b1, 4'd4,  32'd0,         32'd1,         64'h0000_0001_0000_0001, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 1'b0, 4'd0,  32'd0,         32'd0,         64'h0000_0001_0000_0002, 1'b0);
        vecs[6]  = mk(1'b1, 1'b1, 1'b0, 4'd4,  32'd0,         32'd0,         64'd2,                   1'b0);
        vecs[7]  = mk(1'b1, 1'b1, 1'b0, 4'd0,  32'd0,         32'd0,         64'd0,                   1'b0);
        vecs[8]  = mk(1'b1, 1'b1, 1'b0, 4'd12, 32'd0,         32'd0,         64'd1,                   1'b0);
        vecs[9]  = mk(1'b1, 1'b1, 1'b0, 4'd8,  32'd20,        32'd0,         64'd2,                   1'b0);
        vecs[10] = mk(1'b0, 1'b0, 1'b0, 4'd0,  32'd0,         32'd0,         64'd22,                  1'b1);
        vecs[11] = mk(1'b1, 1'b0, 1'b1, 4'd8,  32'd0,         32'd20,        64'd23,                  1'b1);
        vecs[12] = mk(1'b1, 1'b1, 1'b0, 4'd12, 32'hFFFF_FFFF, 32'd0,         64'd24,                  1'b1);
        vecs[13] = mk(1'b0, 1'b0, 1'b0, 4'd0,  32'd0,         32'd0,         64'd25,                  1'b0);
        vecs[14] = mk(1'b1, 1'b0, 1'b1, 4'd12, 32'd0,         32'hFFFF_FFFF, 64'd26,                  1'b0);
        vecs[15] = mk(1'b1, 1'b1, 1'b0, 4'd8,  32'h55,        32'd0,         64'd27,                  1'b0);
        vecs[16] = mk(1'b1, 1'b1, 1'b1, 4'd8,  32'hAA,        32'h55,        64'd28,                  1'b0);
        vecs[17] = mk(1'b1, 1'b0, 1'b1, 4'd8,  32'd0,         32'hAA,        64'd29,                  1'b0);
        vecs[18] = mk(1'b1, 1'b0, 1'b1, 4'd0,  32'd0,         32'd29,        64'd30,                  1'b0);
        vecs[19] = mk(1'b0, 1'b1, 1'b1, 4'd0,  32'h1234,      32'd0,         64'd31,                  1'b0);
        vecs[20] = mk(1'b1, 1'b1, 1'b0, 4'd4,  32'hFFFF_FFFF, 32'd0,         64'hFFFF_FFFF_0000_001F, 1'b0);
        vecs[21] = mk(1'b1, 1'b1, 1'b0, 4'd0,  32'hFFFF_FFFE, 32'd0,         64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        vecs[22] = mk(1'b0, 1'b0, 1'b0, 4'd0,  32'd0,         32'd0,         64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        vecs[23] = mk(1'b0, 1'b0, 1'b0, 4'd0,  32'd0,         32'd0,         64'd0,                   1'b1);
        vecs[24] = mk(1'b0, 1'b0, 1'b0, 4'd0,  32'd0,         32'd0,         64'd1,                   1'b0);
        vecs[25] = mk(1'b1, 1'b0, 1'b1, 4'd4,  32'd0,         32'd0,         64'd2,                   1'b0);
        vecs[26] = mk(1'b1, 1'b1, 1'b0, 4'd12, 32'd0,         32'd0,         64'd3,                   1'b0);
        vecs[27] = mk(1'b1, 1'b1, 1'b0, 4'd0,  32'd500,       32'd0,         64'd500,                 1'b0);
        vecs[28] = mk(1'b1, 1'b0, 1'b1, 4'd0,  32'd0,         32'd500,       64'd501,                 1'b1);
        vecs[29] = mk(1'b1, 1'b0, 1'b1, 4'd8,  32'd0,         32'hFFFF_FFFF, 64'd1,                   1'b0);
        vecs[30] = mk(1'b1, 1'b0, 1'b1, 4'd12, 32'd0,         32'hFFFF_FFFF, 64'd2,                   1'b0);
        vecs[31] = mk(1'b0, 1'b0, 1'b0, 4'd0,  32'd0,         32'd0,         64'd3,                   1'b0);

        // Reset both instances.
        @(negedge clk);
        step();
        step();
        chk("rst_mtime", mtime1, 64'd0);
        chk("rst_irq", 64'(irq1), 64'd0);
        chk("rst_valid", 64'(valid1), 64'd0);
        chk("rst_rdata", 64'(rdata1), 64'd0);
        chk("rst4_mtime", mtime4, 64'd0);
        chk("rst4_rdata", 64'(rdata4), 64'd0);
        rst_n = 1'b1;

        // Free run with PRESCALE_DIV=1.
        for (int i = 0; i < 10; i++) begin
            step();
        end
        chk("run10_mtime", mtime1, 64'd10);
        chk("run10_irq", 64'(irq1), 64'd0);
        chk("run10_valid", 64'(valid1), 64'd0);

        // Carry into HI, then mtimecmp = 20 with mtime counting from 0.
        for (int i = 0; i < 10; i++) begin
            apply(vecs[i]);
        end

        // Count up to 20: request must stay low through mtime_out==20.
        for (int i = 0; i < 40 && mtime1 !== 64'd20; i++) begin
            step();
            chk("pre_cmp_irq", 64'(irq1), 64'd0);
        end
        chk("reach20", mtime1, 64'd20);
        step();
        chk("irq_rise_mtime", mtime1, 64'd21);
        chk("irq_rise", 64'(irq1), 64'd1);

        for (int i = 10; i < 29; i++) begin
            apply(vecs[i]);
        end

        // Reset mid-operation with a read in the same cycle (mtime=501, irq=1).
        rst_n = 1'b0;
        sel1  = 1'b1;
        re    = 1'b1;
        addr  = 4'd0;
        step();
        sel1  = 1'b0;
        re    = 1'b0;
        chk("midrst_mtime", mtime1, 64'd0);
        chk("midrst_irq", 64'(irq1), 64'd0);
        chk("midrst_valid", 64'(valid1), 64'd0);
        chk("midrst_rdata", 64'(rdata1), 64'd0);
        rst_n   = 1'b1;
        last_rd = 32'd0;

        for (int i = 29; i < 32; i++) begin
            apply(vecs[i]);
        end

        // PRESCALE_DIV=4: mtime advances on every fourth edge after reset.
        rst_n4 = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            step();
            chk("div4_mtime", mtime4, 64'(n / 4));
            chk("div4_irq", 64'(irq4), 64'd0);
        end

        // Write on a tick edge (44) suppresses the increment; write on a
        // non-tick edge (49) leaves the prescaler phase alone.
        for (int n = 41; n <= 52; n++) begin
            if (n == 44 || n == 49) begin
                sel4  = 1'b1;
                we    = 1'b1;
                addr  = 4'd0;
                wdata = (n == 44) ? 32'd100 : 32'd200;
            end
            step();
            sel4 = 1'b0;
            we   = 1'b0;
            chk("div4_wr_mtime", mtime4,
                (n < 44) ? 64'd10 : (n < 48) ? 64'd100 : (n == 48) ? 64'd101 :
                (n < 52) ? 64'd200 : 64'd201);
        end

        // Read pulse on u_dut4 and data hold afterwards.
        sel4 = 1'b1;
        re   = 1'b1;
        addr = 4'd0;
        step();
        sel4 = 1'b0;
        re   = 1'b0;
        chk("div4_rd_valid", 64'(valid4), 64'd1);
        chk("div4_rd_data", 64'(rdata4), 64'd201);
        step();
        chk("div4_rd_pulse", 64'(valid4), 64'd0);
        chk("div4_rd_hold", 64'(rdata4), 64'd201);

        step();
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
